// File: rtl/mux_arb_n.sv
// N-to-1 registered mux/arbiter with valid/ready handshake.
// Mode 0: explicit channel select. Mode 1: round-robin with packet locking.
// One output register stage; sustains one beat per cycle.

// Per-channel grant/mask slice: raises ready for the chosen channel and
// gates its beat onto the shared AND-OR data bus.
module mux_arb_lane #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2,
  parameter int IDX    = 0
) (
  input  logic [SEL_W-1:0]  chosen,
  input  logic              chosen_vld,
  input  logic              slot_free,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              xfer,
  output logic [DATA_W-1:0] data_m,
  output logic              last_m
);
  assign ready  = slot_free & chosen_vld & (chosen == SEL_W'(IDX));
  assign xfer   = ready & valid;
  assign data_m = xfer ? data : '0;
  assign last_m = xfer & last;
endmodule

module mux_arb_n #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_port,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_last,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  output logic                     out_last,
  input  logic                     out_ready
);
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t                          state, state_nx;
  logic [SEL_W-1:0]                rr_ptr, lock_ch, chosen;
  logic                            chosen_vld, slot_free, xfer_any, last_any;
  logic [NUM_IN-1:0]               xfer, last_m;
  logic [NUM_IN-1:0][DATA_W-1:0]   data_m;
  logic [DATA_W-1:0]               sel_data;

  assign slot_free = ~out_valid | out_ready;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    mux_arb_lane #(.DATA_W(DATA_W), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .chosen     (chosen),
      .chosen_vld (chosen_vld),
      .slot_free  (slot_free),
      .valid      (in_valid[i]),
      .last       (in_last[i]),
      .data       (in_data[i*DATA_W +: DATA_W]),
      .ready      (in_ready[i]),
      .xfer       (xfer[i]),
      .data_m     (data_m[i]),
      .last_m     (last_m[i])
    );
  end

  assign xfer_any = |xfer;
  assign last_any = |last_m;

  // OR-reduce the one-hot gated lane data into the accepted beat
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) sel_data = sel_data | data_m[i];
  end

  // FSM state register plus round-robin pointer and lock channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_ptr  <= SEL_W'(NUM_IN - 1);
      lock_ch <= '0;
    end else begin
      state <= state_nx;
      // pointer moves only on a mode-1 transfer; in LOCK it already equals lock_ch
      if (mode && xfer_any) begin
        rr_ptr  <= chosen;
        lock_ch <= chosen;
      end
    end
  end

  // FSM next state: open a packet on a non-last beat, close it on last;
  // leaving round-robin mode always drops any lock
  always_comb begin
    state_nx = state;
    if (!mode)         state_nx = ARB;
    else if (xfer_any) state_nx = last_any ? ARB : LOCK;
  end

  // FSM output: pick the channel that may transfer this cycle
  always_comb begin
    logic [SEL_W-1:0] cand;
    chosen     = '0;
    chosen_vld = 1'b0;
    cand       = '0;
    if (!mode) begin
      if (int'(sel_port) < NUM_IN) begin
        chosen     = sel_port;
        chosen_vld = 1'b1;
      end
    end else if (state == LOCK) begin
      chosen     = lock_ch;
      chosen_vld = 1'b1;
    end else begin
      // scan farthest-first so the nearest valid channel after rr_ptr wins
      for (int k = NUM_IN; k >= 1; k--) begin
        cand = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
        if (in_valid[cand]) begin
          chosen     = cand;
          chosen_vld = 1'b1;
        end
      end
    end
  end

  // Output register: load on transfer (drain and reload in one cycle), else drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (xfer_any) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= chosen;
      out_last  <= last_any;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: directed scenarios with literal expectations, then
// randomized handshake traffic scored against a beat-level reference model.
module tb_mux_arb_n;
  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk, rst_n, mode, out_ready;
  logic [S-1:0]   sel_port;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_last;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;

  int tests = 0;
  int fails = 0;

  mux_arb_n #(.DATA_W(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_port(sel_port),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: what the output register must hold and who may go next
  logic         m_vld, m_last, m_lock;
  logic [W-1:0] m_data;
  int           m_src, m_ptr, m_lch;
  logic [N-1:0] acc_q;

  always @(negedge clk) begin
    int ch;
    logic free;
    logic [N-1:0] er;
    if (!rst_n) begin
      m_vld = 0; m_data = 0; m_src = 0; m_last = 0;
      m_ptr = N - 1; m_lock = 0; m_lch = 0;
    end
    chk("m out_valid", out_valid, m_vld);
    chk("m out_data", out_data, m_data);
    chk("m out_src", out_src, 64'(m_src));
    chk("m out_last", out_last, m_last);
    free = !m_vld || out_ready;
    ch = -1;
    if (!mode) ch = (int'(sel_port) < N) ? int'(sel_port) : -1;
    else if (m_lock) ch = m_lch;
    else
      for (int k = 1; k <= N; k++)
        if (in_valid[(m_ptr + k) % N]) begin ch = (m_ptr + k) % N; break; end
    er = (free && ch >= 0) ? N'(1) << ch : '0;
    chk("m in_ready", in_ready, er);
    acc_q = rst_n ? (er & in_valid) : '0;
    if (rst_n) begin
      if (acc_q != 0) begin
        m_vld = 1; m_data = in_data[ch*W +: W]; m_src = ch; m_last = in_last[ch];
        if (mode) begin m_ptr = ch; m_lch = ch; m_lock = !in_last[ch]; end
      end else if (out_ready) m_vld = 0;
      if (!mode) m_lock = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; mode = 0; sel_port = 0; in_valid = 0; in_last = 0; in_data = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_src", out_src, 0);
    chk("rst out_last", out_last, 0);
    // 1: explicit select of channel 1
    rst_n = 1; sel_port = 1; in_valid = 4'hf; in_last = 4'h0;
    in_data = {32'h1111_1111, 32'h1010_1010, 32'h1111_0000, 32'h0000_1111};
    #1 chk("t1 in_ready", in_ready, 4'b0010);
    step; chk("t1 out_data", out_data, 32'h1111_0000); chk("t1 out_src", out_src, 1);
    chk("t1 out_valid", out_valid, 1);
    // 2: select channel 3, then stall three cycles
    sel_port = 3;
    step; chk("t2 out_data", out_data, 32'h1111_1111); chk("t2 out_src", out_src, 3);
    out_ready = 0; in_data[3*W +: W] = 32'h3333_3333;
    #1 chk("t2 stall in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step; chk("t2 held data", out_data, 32'h1111_1111); chk("t2 held valid", out_valid, 1);
      chk("t2 held in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 chk("t2 release in_ready", in_ready, 4'b1000);
    step; chk("t2 b2b data", out_data, 32'h3333_3333); chk("t2 b2b valid", out_valid, 1);
    // 3: round-robin, single-beat packets on every channel
    mode = 1; in_last = 4'hf; in_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      step; chk("t3 rr src", out_src, 64'(i % 4)); chk("t3 rr valid", out_valid, 1);
    end
    // 4: move pointer to 1, then ch2 sends a 3-beat packet
    in_valid = 4'b0010;
    step; chk("t4 pre src", out_src, 1);
    in_valid = 4'hf; in_last = 4'b1011;
    step; chk("t4 beat1 src", out_src, 2); chk("t4 beat1 last", out_last, 0);
    chk("t4 lock in_ready", in_ready, 4'b0100);
    step; chk("t4 beat2 src", out_src, 2);
    in_last = 4'hf;
    step; chk("t4 beat3 src", out_src, 2); chk("t4 beat3 last", out_last, 1);
    step; chk("t4 after src", out_src, 3);
    // 5: lone requesters, idle gaps, wrap-around
    in_valid = 4'b1000;
    step; chk("t5 ch3 src", out_src, 3);
    in_valid = 0;
    step; chk("t5 idle1 valid", out_valid, 0);
    step; chk("t5 idle2 valid", out_valid, 0);
    in_valid = 4'b0010;
    step; chk("t5 ch1 src", out_src, 1);
    in_valid = 4'b1010;
    step; chk("t5 next src", out_src, 3);
    step; chk("t5 wrap src", out_src, 1);
    // 6: reset while locked with a held beat
    in_valid = 4'b0001; in_last = 4'h0;
    step; chk("t6 lock src", out_src, 0); chk("t6 lock valid", out_valid, 1);
    out_ready = 0;
    step; chk("t6 held valid", out_valid, 1);
    rst_n = 0;
    #1 chk("t6 async clear", out_valid, 0);
    step; rst_n = 1; in_valid = 4'hf; in_last = 4'hf; out_ready = 1;
    step; chk("t6 first src", out_src, 0);
    step; chk("t6 second src", out_src, 1);
    // randomized traffic; a pending beat is held until accepted
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 399) == 0) rst_n = 0;
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel_port = S'($urandom_range(0, N - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++)
        if (!in_valid[c] || acc_q[c]) begin
          in_valid[c] = ($urandom_range(0, 9) < 6);
          in_data[c*W +: W] = $urandom;
          in_last[c] = ($urandom_range(0, 2) == 0);
        end
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
